// File: rtl/slowmem_arbiter.sv
// Round-robin arbiter sharing one slowmem port between two instruction caches.
// One access in flight at a time; reads wait for mem_mfc, writes complete after the strobe.
module slowmem_arbiter #(
  parameter int unsigned MEMDELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [1:0]  rnotw,
  output logic [1:0]  done,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        mem_strobe,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rnotw,
  input  logic        mem_mfc,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(MEMDELAY + 2);
  localparam logic [CntW-1:0] FlushLen = CntW'(MEMDELAY + 1);

  typedef enum logic [1:0] {StFlush, StIdle, StIssue, StWait} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_ptr, w_ptr_d;
  logic            r_port, w_port_d;
  logic            r_strobe, w_strobe_d;
  logic [15:0]     r_addr, w_addr_d;
  logic [15:0]     r_wdata, w_wdata_d;
  logic            r_rnotw, w_rnotw_d;
  logic [1:0]      r_done, w_done_d;
  logic [15:0]     r_rdata, w_rdata_d;
  logic            r_busy, w_busy_d;
  logic [1:0]      w_eff;
  logic            w_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StFlush;
      r_cnt    <= FlushLen;
      r_ptr    <= 1'b1;
      r_port   <= 1'b0;
      r_strobe <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rnotw  <= 1'b1;
      r_done   <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_ptr    <= w_ptr_d;
      r_port   <= w_port_d;
      r_strobe <= w_strobe_d;
      r_addr   <= w_addr_d;
      r_wdata  <= w_wdata_d;
      r_rnotw  <= w_rnotw_d;
      r_done   <= w_done_d;
      r_rdata  <= w_rdata_d;
      r_busy   <= w_busy_d;
    end
  end

  // The port just completed is masked for the cycle its done is visible.
  assign w_eff   = req & ~r_done;
  assign w_grant = (w_eff == 2'b11) ? ~r_ptr : w_eff[1];

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_ptr_d    = r_ptr;
    w_port_d   = r_port;
    w_strobe_d = 1'b0;
    w_addr_d   = r_addr;
    w_wdata_d  = r_wdata;
    w_rnotw_d  = r_rnotw;
    w_done_d   = '0;
    w_rdata_d  = r_rdata;
    unique case (r_state)
      StFlush: begin
        w_cnt_d = r_cnt - 1'b1;
        if (r_cnt <= CntW'(1)) w_state_d = StIdle;
      end
      StIdle: begin
        if (|w_eff) begin
          w_port_d   = w_grant;
          w_ptr_d    = w_grant;
          w_strobe_d = 1'b1;
          w_addr_d   = w_grant ? addr1 : addr0;
          w_wdata_d  = w_grant ? wdata1 : wdata0;
          w_rnotw_d  = rnotw[w_grant];
          w_state_d  = StIssue;
        end
      end
      StIssue: begin
        if (r_rnotw) begin
          w_state_d = StWait;
        end else begin
          w_done_d  = r_port ? 2'b10 : 2'b01;
          w_state_d = StIdle;
        end
      end
      StWait: begin
        if (mem_mfc) begin
          w_rdata_d = mem_rdata;
          w_done_d  = r_port ? 2'b10 : 2'b01;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StFlush;
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  assign done       = r_done;
  assign rdata      = r_rdata;
  assign busy       = r_busy;
  assign mem_strobe = r_strobe;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_rnotw  = r_rnotw;

endmodule

// File: tb/tb_slowmem_arbiter.sv
// Bench for slowmem_arbiter: transaction-level model checked every cycle,
// slowmem behavioural model, and directed scenarios with literal expectations.
module tb_slowmem_arbiter;
  localparam int MEMDELAY = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  rnotw = 2'b11;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  done;
  logic [15:0] rdata;
  logic        busy, mem_strobe, mem_rnotw;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_mfc = 1'b0;
  logic [15:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int tcyc = 0;

  slowmem_arbiter #(.MEMDELAY(MEMDELAY)) dut (
    .clk(clk), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .rnotw(rnotw), .done(done), .rdata(rdata),
    .busy(busy), .mem_strobe(mem_strobe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rnotw(mem_rnotw), .mem_mfc(mem_mfc), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Slowmem: one-entry write store over fixed default contents; not reset by the arbiter.
  logic [15:0] ws_addr = '0, ws_data = '0;
  logic        ws_valid = 1'b0;
  int          rd_cnt = 0;
  logic [15:0] rd_addr = '0;

  function automatic logic [15:0] mem_default(input logic [15:0] a);
    case (a)
      16'h0010: return 16'h1234;
      16'h0020: return 16'h5678;
      16'h0100: return 16'hA0A0;
      16'h0200: return 16'hB0B0;
      default:  return a ^ 16'hFFFF;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_mfc <= 1'b0;
    if (rd_cnt == 1) begin
      mem_mfc   <= 1'b1;
      mem_rdata <= (ws_valid && ws_addr == rd_addr) ? ws_data : mem_default(rd_addr);
    end
    if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
    if (mem_strobe) begin
      if (mem_rnotw) begin
        rd_cnt  <= MEMDELAY;
        rd_addr <= mem_addr;
      end else begin
        ws_valid <= 1'b1;
        ws_addr  <= mem_addr;
        ws_data  <= mem_wdata;
      end
    end
  end

  // Observation log for the directed checks.
  int          strobe_cnt = 0, strobe_t = 0, d0cnt = 0, d1cnt = 0;
  logic [15:0] glog[$];

  always @(negedge clk) begin
    if (mem_strobe) begin
      strobe_cnt++;
      strobe_t = tcyc;
      glog.push_back(mem_addr);
    end
    if (done[0]) d0cnt++;
    if (done[1]) d1cnt++;
  end

  // Model: cycle k counts from reset release; arbiter idle from m_avail onward.
  int          k = -1, m_avail = 0, m_rd_from = 0, m_strobe_cyc = -10, m_done_cyc = -10;
  bit          m_pend = 0, m_ptr = 1, m_port = 0, g = 0;
  logic [1:0]  m_done_val = '0, e_done, eff;
  logic [15:0] x_addr = '0, x_wdata = '0, x_rdata = '0;
  logic        x_rnotw = 1'b1;
  logic [1:0]  p_req = '0, p_rnotw = '0, p_done = '0;
  logic [15:0] p_a0 = '0, p_a1 = '0, p_w0 = '0, p_w1 = '0, p_mrd = '0;
  logic        p_mfc = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      k = -1; m_avail = MEMDELAY + 1; m_pend = 0; m_ptr = 1;
      m_strobe_cyc = -10; m_done_cyc = -10; m_done_val = '0;
      x_addr = '0; x_wdata = '0; x_rdata = '0; x_rnotw = 1'b1;
    end else begin
      k++;
      if (k >= 1) begin
        if (m_pend && (k - 1) >= m_rd_from && p_mfc) begin
          m_pend = 0; m_done_cyc = k; m_done_val = m_port ? 2'b10 : 2'b01;
          x_rdata = p_mrd; m_avail = k;
        end else if (!m_pend && (k - 1) >= m_avail) begin
          eff = p_req & ~p_done;
          if (eff != 2'b00) begin
            g = (eff == 2'b11) ? !m_ptr : eff[1];
            m_ptr = g; m_port = g; m_strobe_cyc = k;
            x_addr  = g ? p_a1 : p_a0;
            x_wdata = g ? p_w1 : p_w0;
            x_rnotw = p_rnotw[g];
            if (x_rnotw) begin
              m_pend = 1; m_rd_from = k + 1; m_avail = 1 << 30;
            end else begin
              m_done_cyc = k + 1; m_done_val = g ? 2'b10 : 2'b01; m_avail = k + 1;
            end
          end
        end
      end
    end
    e_done = (k == m_done_cyc) ? m_done_val : 2'b00;
    chk("busy", 16'(busy), 16'(k < m_avail));
    chk("mem_strobe", 16'(mem_strobe), 16'(k == m_strobe_cyc));
    chk("done", 16'(done), 16'(e_done));
    chk("rdata", rdata, x_rdata);
    chk("mem_addr", mem_addr, x_addr);
    chk("mem_wdata", mem_wdata, x_wdata);
    chk("mem_rnotw", 16'(mem_rnotw), 16'(x_rnotw));
    p_req = req; p_rnotw = rnotw; p_a0 = addr0; p_a1 = addr1; p_w0 = wdata0; p_w1 = wdata1;
    p_mfc = mem_mfc; p_mrd = mem_rdata; p_done = e_done;
  end

  task automatic wait_done(input int port, output int t);
    int n;
    t = -1;
    n = 0;
    while (t < 0 && n < 40) begin
      @(negedge clk);
      if (done[port]) t = tcyc;
      n++;
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout port %0d: no done within 40 cycles, required one", port);
    end
  endtask

  task automatic wait_strobe(output int t);
    int n;
    t = -1;
    n = 0;
    while (t < 0 && n < 40) begin
      @(negedge clk);
      if (mem_strobe) t = tcyc;
      n++;
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL strobe_timeout: no strobe within 40 cycles, required one");
    end
  endtask

  // Requester: holds req until done is seen, drops it at the next edge.
  task automatic access(input int port, input logic rd, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] exp_rd);
    int t;
    if (port == 0) begin addr0 = a; wdata0 = wd; end
    else begin addr1 = a; wdata1 = wd; end
    rnotw[port] = rd;
    req[port] = 1'b1;
    wait_done(port, t);
    if (t >= 0) begin
      chk("done_vec", 16'(done), (port == 0) ? 16'h0001 : 16'h0002);
      chk("latency", 16'(t - strobe_t), rd ? 16'd6 : 16'd1);
      if (rd) chk("read_data", rdata, exp_rd);
    end
    @(posedge clk); #1;
    req[port] = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t, s0, d0;
    repeat (3) @(posedge clk);
    #1;
    // Both ports request reads from before the first IDLE cycle.
    addr0 = 16'h0100; addr1 = 16'h0200; rnotw = 2'b11; req = 2'b11;
    reset = 1'b1;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("flush_busy_cycles", 16'(n), 16'd5);
    chk("flush_strobes", 16'(strobe_cnt), 16'd0);
    chk("flush_done", 16'(done), 16'd0);
    @(posedge clk); #1;

    fork
      begin
        for (int j = 0; j < 2; j++) access(0, 1'b1, 16'h0100, 16'h0000, 16'hA0A0);
      end
      begin
        for (int j = 0; j < 2; j++) access(1, 1'b1, 16'h0200, 16'h0000, 16'hB0B0);
      end
    join
    chk("rr_grants", 16'(glog.size()), 16'd4);
    if (glog.size() == 4) begin
      chk("rr_g0", glog[0], 16'h0100);
      chk("rr_g1", glog[1], 16'h0200);
      chk("rr_g2", glog[2], 16'h0100);
      chk("rr_g3", glog[3], 16'h0200);
    end
    chk("rr_done0", 16'(d0cnt), 16'd2);
    chk("rr_done1", 16'(d1cnt), 16'd2);

    access(0, 1'b1, 16'h0010, 16'h0000, 16'h1234);
    access(1, 1'b0, 16'h8000, 16'hBEEF, 16'h0000);
    access(1, 1'b1, 16'h8000, 16'h0000, 16'hBEEF);

    // req[0] stays high through the done cycle: exactly one strobe.
    s0 = strobe_cnt;
    access(0, 1'b0, 16'h0030, 16'h1111, 16'h0000);
    repeat (6) @(posedge clk);
    #1;
    chk("no_reissue", 16'(strobe_cnt - s0), 16'd1);

    // Reset three cycles into a read; the aborted read must never complete.
    addr0 = 16'h0010; rnotw[0] = 1'b1; req[0] = 1'b1;
    wait_strobe(t);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; req[0] = 1'b0;
    d0 = d0cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    access(0, 1'b1, 16'h0020, 16'h0000, 16'h5678);
    repeat (4) @(posedge clk);
    #1;
    chk("reset_abort_done_count", 16'(d0cnt - d0), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slowmem_arbiter.md
# slowmem_arbiter

Two-port request arbiter between the per-PID instruction caches and the single `slowmem` port. It accepts one read or write request at a time from cache 0 (PID 0) or cache 1 (PID 1), drives `slowmem`'s strobe/addr/wdata/rnotw, waits for `mfc` on reads, and returns read data with a one-cycle `done` pulse to the winning cache. Arbitration is round-robin so neither PID can starve the other.

## Interface
- `MEMDELAY`, 4: slowmem read latency; also sets post-reset flush length.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `req`  in  2  bit i = request pending from cache i; level, held until `done[i]`.
- `addr0`, `addr1`  in  16  request address per port.
- `wdata0`, `wdata1`  in  16  write data per port.
- `rnotw`  in  2  bit i: 1 = read, 0 = write.
- `done`  out  2  one-cycle pulse: request i completed.
- `rdata`  out  16  read data, valid only while a `done` bit for a read is high.
- `busy`  out  1  high in any state other than IDLE.
- `mem_strobe`  out  1  to slowmem `strobe`.
- `mem_addr`  out  16  to slowmem `addr`.
- `mem_wdata`  out  16  to slowmem `wdata`.
- `mem_rnotw`  out  1  to slowmem `rnotw`.
- `mem_mfc`  in  1  from slowmem `mfc`.
- `mem_rdata`  in  16  from slowmem `rdata`.

## Operation
- States: FLUSH, IDLE, ISSUE, WAIT. All outputs registered.
- Reset (reset==0): state FLUSH, flush counter = MEMDELAY+1, `mem_strobe`=0, `mem_rnotw`=1, `mem_addr`=0, `mem_wdata`=0, `done`=0, `rdata`=0, `busy`=1, last-grant pointer = 1 (so port 0 wins first tie).
- FLUSH: decrement counter each cycle, ignore `req` and `mem_mfc`; at 0 go IDLE. Drains any read slowmem had pending when reset hit.
- IDLE: effective request e[i] = `req[i]` & ~`done[i]`. Neither set: stay. One set: grant it. Both set: grant the port not equal to last-grant pointer. On grant: latch that port's addr/wdata/rnotw onto mem_* outputs, `mem_strobe`<=1, update pointer, go ISSUE.
- ISSUE (strobe high exactly one cycle): `mem_strobe`<=0. Write: `done[i]`<=1, go IDLE. Read: go WAIT.
- WAIT: `mem_mfc`==1 -> `rdata`<=`mem_rdata`, `done[i]`<=1, go IDLE; else stay. No timeout.
- `mem_mfc` in IDLE/ISSUE/FLUSH ignored.
- `done` cleared to 0 the cycle after it is set; never both bits high.
- mem_addr/wdata/rnotw hold last value when not strobing.
- Request inputs changing after grant have no effect on the in-flight access.

## Timing
- Grant edge = edge 0 (IDLE samples e[i]=1). `mem_strobe` high cycle 0->1.
- Write: slowmem writes at edge 1; `done[i]` high cycle 1->2. Latency 1 cycle grant-to-done.
- Read (MEMDELAY=4): slowmem captures at edge 1, `mem_mfc` high after edge 5, arbiter captures at edge 6; `done[i]`/`rdata` valid cycle 6->7.
- Back-to-back: earliest next grant at the edge ending the `done` cycle (edge 2 after a write, edge 7 after a read). The just-finished port is masked in that cycle, so a requester that drops `req` on seeing `done` is never re-issued.
- Never strobe while `mem_mfc` may still be high: guaranteed because IDLE always follows a WAIT completion by one cycle.
- Reset mid-WAIT: outputs reset asynchronously; stale `mem_mfc` during FLUSH discarded; no `done` for the aborted request.

## Test plan
- Reset release, no req: `busy`=1 for 5 cycles (FLUSH), then 0; `mem_strobe` stays 0, `done`=0.
- Port 0 read addr 16'h0010 (mem holds 16'h1234): one strobe cycle with `mem_rnotw`=1, `done`=2'b01 exactly 6 cycles after grant, `rdata`=16'h1234.
- Port 1 write addr 16'h8000 data 16'hBEEF, then port 1 read 16'h8000: write `done`=2'b10 one cycle after grant; read returns 16'hBEEF.
- Both ports hold reads from first IDLE cycle: grants alternate 0,1,0,1; each port sees exactly one `done` per transaction, no double strobe.
- Requester keeps `req[0]` high one extra cycle after `done[0]`: no second strobe for that request.
- Assert reset at cycle 3 of a port 0 read, release, re-request read 16'h0020: no `done` for first read; second completes normally with correct data, no early completion from stale `mem_mfc`.
